fp_alu_issue: RTL

- Sequential front-end that issues operations to the combinational floating-point ALU and returns the results.
- Accepts tagged requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand and opcode ports and holds them stable for a multicycle settle window.
- Captures the ALU result and flags, then returns them over a valid/ready response handshake.

---
 rtl/fp_alu_issue.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_alu_issue.sv
// fp_alu_issue: sequential issue front-end for the combinational floating-point ALU.
// Requests (op, a, b, tag) enter a FIFO over req_valid/req_ready. The head is driven onto
// alu_a/alu_b/alu_op and held for a settle window. The ALU result and flags are then captured
// and returned over rsp_valid/rsp_ready together with the echoed tag.
// Unsupported opcodes bypass the ALU and return an exception response with rsp_illegal set.
// busy is high while the FSM is not idle or the FIFO holds requests.
// Optional: define FP_ALU_ISSUE_STATS_EN to add saturating stat_ops/stat_exc handshake counters.
module fp_alu_issue #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int TAG_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_result,
   input  logic             alu_exception,
   input  logic             alu_overflow,
   input  logic             alu_underflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_exception,
   output logic             rsp_overflow,
   output logic             rsp_underflow,
   output logic             rsp_illegal,
`ifdef FP_ALU_ISSUE_STATS_EN
   output logic [15:0]      stat_ops,
   output logic [15:0]      stat_exc,
`endif
   output logic             busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
   typedef struct packed {
      logic [3:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
   } req_t;
   req_t             mem_q [FIFO_DEPTH];
   req_t             head;
   state_t           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_exc_q, rsp_exc_d, rsp_ovf_q, rsp_ovf_d;
   logic             rsp_unf_q, rsp_unf_d, rsp_ill_q, rsp_ill_d;
   logic             push, pop, hs;

   function automatic logic is_arith(input logic [3:0] op);
      return op inside {4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd12};
   endfunction

   function automatic logic is_logic(input logic [3:0] op);
      return op inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11};
   endfunction

   // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
   assign req_ready = count_q != (AW+1)'(FIFO_DEPTH);
   assign push      = req_valid & req_ready;
   assign pop       = (state_q == IDLE) && (count_q != '0);
   assign hs        = rsp_valid & rsp_ready;
   assign head      = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_op, req_a, req_b, req_tag};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      rsp_data_d = rsp_data_q;
      rsp_tag_d  = rsp_tag_q;
      rsp_exc_d  = rsp_exc_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_unf_d  = rsp_unf_q;
      rsp_ill_d  = rsp_ill_q;
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (is_arith(head.op) || is_logic(head.op)) begin
                  alu_a_d  = head.a;
                  alu_b_d  = head.b;
                  alu_op_d = head.op;
                  cnt_d    = is_arith(head.op) ? 4'(SETTLE_CYCLES) : 4'd1;
                  rsp_tag_d = head.tag;
                  state_d  = DRIVE;
               end else begin
                  rsp_data_d = '0;
                  rsp_tag_d  = head.tag;
                  rsp_exc_d  = 1'b1;
                  rsp_ovf_d  = 1'b0;
                  rsp_unf_d  = 1'b0;
                  rsp_ill_d  = 1'b1;
                  state_d    = RESP;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == 4'd1) begin
               rsp_data_d = alu_result;
               rsp_exc_d  = alu_exception;
               rsp_ovf_d  = alu_overflow;
               rsp_unf_d  = alu_underflow;
               rsp_ill_d  = 1'b0;
               alu_op_d   = 4'd0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cnt_q      <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rsp_data_q <= '0;
         rsp_tag_q  <= '0;
         rsp_exc_q  <= 1'b0;
         rsp_ovf_q  <= 1'b0;
         rsp_unf_q  <= 1'b0;
         rsp_ill_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         rsp_data_q <= rsp_data_d;
         rsp_tag_q  <= rsp_tag_d;
         rsp_exc_q  <= rsp_exc_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_unf_q  <= rsp_unf_d;
         rsp_ill_q  <= rsp_ill_d;
      end
   end

   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;
   assign rsp_valid     = state_q == RESP;
   assign rsp_data      = rsp_data_q;
   assign rsp_tag       = rsp_tag_q;
   assign rsp_exception = rsp_exc_q;
   assign rsp_overflow  = rsp_ovf_q;
   assign rsp_underflow = rsp_unf_q;
   assign rsp_illegal   = rsp_ill_q;
   assign busy          = (state_q != IDLE) || (count_q != '0);

`ifdef FP_ALU_ISSUE_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d, stat_exc_q, stat_exc_d;

   always_comb begin
      stat_ops_d = (hs && stat_ops_q != 16'hFFFF) ? stat_ops_q + 16'd1 : stat_ops_q;
      stat_exc_d = (hs && rsp_exc_q && stat_exc_q != 16'hFFFF) ? stat_exc_q + 16'd1 : stat_exc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q <= '0;
         stat_exc_q <= '0;
      end else begin
         stat_ops_q <= stat_ops_d;
         stat_exc_q <= stat_exc_d;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_exc = stat_exc_q;
`else
   logic unused_hs;
   assign unused_hs = hs;
`endif
endmodule
